// File: rtl/sfifo_wr_arbiter_if.sv
// Write-side bundle between producers, the arbiter and the shared SFIFO write port.
interface sfifo_wr_arbiter_if #(
  parameter int unsigned Depth      = 8,
  parameter int unsigned Width      = 8,
  parameter int unsigned Requesters = 4
);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [Requesters-1:0]       Req;
  logic [Requesters*Width-1:0] ReqData;
  logic                        FIFORdReq;
  logic                        FIFOFull;
  logic                        FIFOWrReq;
  logic [Width-1:0]            WRData;
  logic [Requesters-1:0]       Ack;
  logic [LvlW-1:0]             Level;

  modport master (
    input  Req, ReqData, FIFORdReq, FIFOFull,
    output FIFOWrReq, WRData, Ack, Level
  );

  modport slave (
    output Req, ReqData, FIFORdReq, FIFOFull,
    input  FIFOWrReq, WRData, Ack, Level
  );
endinterface

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin arbiter sharing one SFIFO write port, with optional bursts and a
// shadow occupancy counter that keeps the FIFO from ever being written while full.
module sfifo_wr_arbiter #(
  parameter int unsigned Depth      = 8,
  parameter int unsigned Width      = 8,
  parameter int unsigned Requesters = 4,
  parameter int unsigned MaxBurst   = 1
) (
  input  logic               clk,
  input  logic               reset,
  sfifo_wr_arbiter_if.master bus
);
  localparam int unsigned PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;
  localparam int unsigned LvlW = $clog2(Depth + 1);
  localparam int unsigned BcW  = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q;
  logic [PtrW-1:0]       ptr_q, owner_q;
  logic [BcW-1:0]        burst_cnt_q;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  wr_req_q;
  logic [Width-1:0]      wr_data_q;
  logic [Requesters-1:0] ack_q;

  logic [Requesters-1:0] req_m_c;
  logic                  space_c, keep_c, pick_ok_c, grant_c, dec_c;
  logic [PtrW-1:0]       next_ptr_c, search_ptr_c, pick_idx_c, grant_idx_c;
  logic [PtrW:0]         cand_c;
  logic [LvlW-1:0]       readable_c;

  // A producer still shows Req during its ack cycle, so new arbitration ignores it there.
  always_comb begin
    req_m_c      = bus.Req & ~ack_q;
    space_c      = (level_q < LvlW'(Depth)) && !bus.FIFOFull;
    keep_c       = (state_q == BURST) && bus.Req[owner_q] &&
                   (burst_cnt_q < BcW'(MaxBurst)) && space_c;
    next_ptr_c   = (owner_q == PtrW'(Requesters - 1)) ? '0 : owner_q + PtrW'(1);
    search_ptr_c = (state_q == BURST) ? next_ptr_c : ptr_q;
    pick_ok_c    = 1'b0;
    pick_idx_c   = search_ptr_c;
    cand_c       = '0;
    for (int k = 0; k < int'(Requesters); k++) begin
      cand_c = {1'b0, search_ptr_c} + (PtrW+1)'(k);
      if (cand_c >= (PtrW+1)'(Requesters)) cand_c = cand_c - (PtrW+1)'(Requesters);
      if (!pick_ok_c && req_m_c[cand_c[PtrW-1:0]]) begin
        pick_ok_c  = 1'b1;
        pick_idx_c = cand_c[PtrW-1:0];
      end
    end
    pick_ok_c   = pick_ok_c && space_c;
    grant_c     = keep_c || pick_ok_c;
    grant_idx_c = keep_c ? owner_q : pick_idx_c;
  end

  // The word in flight is not yet readable, so a read against it is ignored by the SFIFO.
  always_comb begin
    readable_c = level_q - LvlW'(wr_req_q);
    dec_c      = bus.FIFORdReq && (readable_c != '0);
    level_d    = level_q + LvlW'(grant_c) - LvlW'(dec_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      level_q     <= '0;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '0;
      ack_q       <= '0;
    end else begin
      level_q  <= level_d;
      wr_req_q <= grant_c;
      ack_q    <= grant_c ? (Requesters'(1) << grant_idx_c) : '0;
      if (grant_c) wr_data_q <= bus.ReqData[int'(grant_idx_c)*int'(Width) +: Width];
      case (state_q)
        IDLE: begin
          if (pick_ok_c) begin
            owner_q     <= pick_idx_c;
            burst_cnt_q <= BcW'(1);
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (keep_c) begin
            burst_cnt_q <= burst_cnt_q + BcW'(1);
          end else begin
            ptr_q <= next_ptr_c;
            if (pick_ok_c) begin
              owner_q     <= pick_idx_c;
              burst_cnt_q <= BcW'(1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.FIFOWrReq = wr_req_q;
  assign bus.WRData    = wr_data_q;
  assign bus.Ack       = ack_q;
  assign bus.Level     = level_q;
endmodule
